// File: rtl/gmii_phy_rx_source.sv
// PHY-side GMII/MII receive source: wraps AXI-stream payload in preamble/SFD, optional pad and FCS,
// paced at 1000/100/10M by an internal clk_en prescaler.
`timescale 1ns/1ps
module gmii_phy_rx_source #(
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG_BYTES        = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  input  logic [1:0] speed,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       clk_en,
  output logic       busy
);

  localparam logic [15:0] MIN_PAYLOAD = 16'(MIN_FRAME_LENGTH - 4);
  localparam logic [15:0] IFG_LAST    = 16'(IFG_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

  state_t      state_q, state_d;
  logic [1:0]  speed_q, speed_d;
  logic [5:0]  presc_q, presc_d;
  logic        nib_q, nib_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        dv_q, dv_d, er_q, er_d, clk_en_q, clk_en_d, drain_q, drain_d;

  logic        spd_chg, tick, slot, gmii, ndv, ner;
  logic [7:0]  nb;
  logic [15:0] len_inc;
  logic [31:0] fcs;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    presc_d  = presc_q;
    nib_d    = nib_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    crc_d    = crc_q;
    hi_d     = hi_q;
    rxd_d    = rxd_q;
    dv_d     = dv_q;
    er_d     = er_q;
    drain_d  = drain_q;
    clk_en_d = 1'b0;
    nb       = 8'h00;
    ndv      = 1'b0;
    ner      = 1'b0;
    fcs      = ~crc_q;
    len_inc  = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    // speed only switches on an idle byte boundary so the last IFG nibble is never cut short
    spd_chg  = (state_q == S_IDLE) && !nib_q && (speed != speed_q);
    tick     = !spd_chg && (presc_q == 6'd0);
    gmii     = speed_q[1];
    slot     = tick && (gmii || !nib_q);

    if (spd_chg) begin
      speed_d = speed;
      presc_d = 6'd0;
    end else if (presc_q == 6'd0) begin
      presc_d = speed_q[1] ? 6'd0 : (speed_q[0] ? 6'd4 : 6'd49);
    end else begin
      presc_d = presc_q - 6'd1;
    end

    s_axis_tready = !rst && (drain_q || (slot && state_q == S_DATA));
    if (drain_q && s_axis_tvalid && s_axis_tlast) drain_d = 1'b0;

    if (slot) begin
      case (state_q)
        S_IDLE: begin
          if (s_axis_tvalid && !drain_q) begin
            nb      = 8'h55;
            ndv     = 1'b1;
            cnt_d   = 16'd5;
            state_d = S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          nb  = 8'h55;
          ndv = 1'b1;
          if (cnt_q == 16'd0) state_d = S_SFD;
          else cnt_d = cnt_q - 16'd1;
        end
        S_SFD: begin
          nb      = 8'hD5;
          ndv     = 1'b1;
          crc_d   = 32'hFFFFFFFF;
          len_d   = 16'd0;
          state_d = S_DATA;
        end
        S_DATA: begin
          ndv = 1'b1;
          if (s_axis_tvalid) begin
            nb    = s_axis_tdata;
            crc_d = crc_step(crc_q, s_axis_tdata);
            len_d = len_inc;
            if (s_axis_tlast) begin
              ner   = s_axis_tuser;
              cnt_d = 16'd0;
              if (ENABLE_PADDING != 0 && len_inc < MIN_PAYLOAD) state_d = S_PAD;
              else state_d = S_FCS;
            end
          end else begin
            ner     = 1'b1;
            drain_d = 1'b1;
            cnt_d   = IFG_LAST;
            state_d = S_IFG;
          end
        end
        S_PAD: begin
          ndv   = 1'b1;
          crc_d = crc_step(crc_q, 8'h00);
          len_d = len_inc;
          if (len_inc >= MIN_PAYLOAD) begin
            cnt_d   = 16'd0;
            state_d = S_FCS;
          end
        end
        S_FCS: begin
          ndv = 1'b1;
          case (cnt_q[1:0])
            2'd0:    nb = fcs[7:0];
            2'd1:    nb = fcs[15:8];
            2'd2:    nb = fcs[23:16];
            default: nb = fcs[31:24];
          endcase
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = IFG_LAST;
            state_d = S_IFG;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_IFG: begin
          if (cnt_q == 16'd0) state_d = S_IDLE;
          else cnt_d = cnt_q - 16'd1;
        end
        default: state_d = S_IDLE;
      endcase
      hi_d  = nb[7:4];
      nib_d = !gmii;
      rxd_d = gmii ? nb : {4'h0, nb[3:0]};
      dv_d  = ndv;
      er_d  = ner;
    end else if (tick) begin
      nib_d = 1'b0;
      rxd_d = {4'h0, hi_q};
    end

    if (tick) clk_en_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      speed_q  <= 2'b10;
      presc_q  <= 6'd0;
      nib_q    <= 1'b0;
      cnt_q    <= 16'd0;
      len_q    <= 16'd0;
      crc_q    <= 32'hFFFFFFFF;
      hi_q     <= 4'h0;
      rxd_q    <= 8'h00;
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      clk_en_q <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      presc_q  <= presc_d;
      nib_q    <= nib_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      crc_q    <= crc_d;
      hi_q     <= hi_d;
      rxd_q    <= rxd_d;
      dv_q     <= dv_d;
      er_q     <= er_d;
      clk_en_q <= clk_en_d;
      drain_q  <= drain_d;
    end
  end

  assign gmii_rxd   = rxd_q;
  assign gmii_rx_dv = dv_q;
  assign gmii_rx_er = er_q;
  assign clk_en     = clk_en_q;
  assign busy       = (state_q != S_IDLE);

endmodule
